// File: rtl/div_unit.sv
// Radix-2 restoring divider for the EXE stage: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve in a single cycle.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            divide_instruction,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    input  logic            hold,
    output logic            divide_stall,
    output logic [XLEN-1:0] div_result,
    output logic            div_valid,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state;
    logic [XLEN-1:0]   dvd;       // dividend shifts out as the quotient shifts in
    logic [XLEN-1:0]   dvs;
    logic [XLEN-1:0]   rem;
    logic [CntW-1:0]   counter;
    logic [2:0]        fun3_q;
    logic              sign_a;
    logic              sign_b;

    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   min_int;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     trial;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic              signed_q;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        is_signed   = ~fun3[0];
        a_neg       = is_signed & op_a[XLEN-1];
        b_neg       = is_signed & op_b[XLEN-1];
        abs_a       = a_neg ? (~op_a + 1'b1) : op_a;
        abs_b       = b_neg ? (~op_b + 1'b1) : op_b;
        min_int     = {1'b1, {(XLEN-1){1'b0}}};
        div_zero    = (op_b == '0);
        overflow    = is_signed & (op_a == min_int) & (op_b == '1);
        if (fun3[1]) special_res = div_zero ? op_a : '0;
        else         special_res = div_zero ? '1 : min_int;

        // Full-width partial remainder keeps the MSB for large unsigned divisors.
        trial     = {rem, dvd[XLEN-1]} - {1'b0, dvs};
        q_bit     = ~trial[XLEN];
        rem_next  = q_bit ? trial[XLEN-1:0] : {rem[XLEN-2:0], dvd[XLEN-1]};
        quo_next  = {dvd[XLEN-2:0], q_bit};
        signed_q  = ~fun3_q[0];
        quo_fix   = (signed_q & (sign_a ^ sign_b)) ? (~quo_next + 1'b1) : quo_next;
        rem_fix   = (signed_q & sign_a) ? (~rem_next + 1'b1) : rem_next;
        final_res = fun3_q[1] ? rem_fix : quo_fix;
    end

    assign divide_stall = ~reset & divide_instruction & ~flush & (state != StDone);
    assign busy         = (state == StBusy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            counter    <= '0;
            fun3_q     <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div_result <= '0;
            div_valid  <= 1'b0;
        end else if (flush) begin
            state     <= StIdle;
            div_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (divide_instruction) begin
                        dvd    <= abs_a;
                        dvs    <= abs_b;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        fun3_q <= fun3;
                        rem    <= '0;
                        if (div_zero || overflow) begin
                            div_result <= special_res;
                            div_valid  <= 1'b1;
                            state      <= StDone;
                        end else begin
                            counter <= CntW'(XLEN - 1);
                            state   <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (!divide_instruction) begin
                        state <= StIdle;
                    end else begin
                        dvd     <= quo_next;
                        rem     <= rem_next;
                        counter <= counter - 1'b1;
                        if (counter == '0) begin
                            div_result <= final_res;
                            div_valid  <= 1'b1;
                            state      <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (!hold) begin
                        state     <= StIdle;
                        div_valid <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
